// File: rtl/ccd_bayer_rgb_if.sv
// rtl/ccd_bayer_rgb_if.sv - raw Bayer pixel input and quad RGB output bundle for ccd_bayer_rgb
interface ccd_bayer_rgb_if #(
  parameter int CW = 12
);
  logic [9:0]    iDATA;
  logic          iDVAL;
  logic [31:0]   iFrame_Cont;
  logic [9:0]    oRed;
  logic [9:0]    oGreen;
  logic [9:0]    oBlue;
  logic          oDVAL;
  logic [CW-1:0] oX_Cont;
  logic [CW-1:0] oY_Cont;

  modport master (
    output iDATA, iDVAL, iFrame_Cont,
    input  oRed, oGreen, oBlue, oDVAL, oX_Cont, oY_Cont
  );

  modport slave (
    input  iDATA, iDVAL, iFrame_Cont,
    output oRed, oGreen, oBlue, oDVAL, oX_Cont, oY_Cont
  );
endinterface

// File: rtl/ccd_bayer_rgb.sv
// rtl/ccd_bayer_rgb.sv - Bayer quad to RGB using one line buffer; GREEN_AVG_EN averages both greens
// Pattern: even rows G R, odd rows B G; one output per completed 2x2 quad.
module ccd_bayer_rgb #(
  parameter int H_ACTIVE = 1280,
  parameter int CW       = 12
) (
  input logic            iCLK,
  input logic            iRST,
  ccd_bayer_rgb_if.slave bus
);
  localparam int AW = (H_ACTIVE > 2) ? $clog2(H_ACTIVE) : 1;

  logic          frame_q;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [9:0]    p10_q;
  logic [9:0]    line_mem [H_ACTIVE];

  logic          frame_chg;
  logic [CW-1:0] x_cur, y_cur;
  logic [AW-1:0] addr;
  logic [9:0]    p01;
  logic          quad;
  logic [9:0]    green_d;

  logic [9:0]    red_q, green_q, blue_q;
  logic          dval_q;
  logic [CW-1:0] xo_q, yo_q;

  // A frame edge restarts the raster on this very cycle, so a coincident pixel lands at (0,0).
  assign frame_chg = frame_q ^ bus.iFrame_Cont[0];
  assign x_cur     = frame_chg ? '0 : x_q;
  assign y_cur     = frame_chg ? '0 : y_q;
  assign addr      = x_cur[AW-1:0];
  assign p01       = line_mem[addr];
  assign quad      = bus.iDVAL & x_cur[0] & y_cur[0];

  always_comb begin
    x_d = x_cur;
    y_d = y_cur;
    if (bus.iDVAL) begin
      if (x_cur == CW'(H_ACTIVE - 1)) begin
        x_d = '0;
        y_d = y_cur + 1'b1;
      end else begin
        x_d = x_cur + 1'b1;
      end
    end
  end

`ifdef GREEN_AVG_EN
  logic [9:0]  p00_q;
  logic [10:0] g_sum;

  assign g_sum   = {1'b0, p00_q} + {1'b0, bus.iDATA};
  assign green_d = g_sum[10:1];

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      p00_q <= '0;
    end else if (bus.iDVAL) begin
      p00_q <= p01;
    end
  end
`else
  assign green_d = bus.iDATA;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      frame_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      p10_q   <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      dval_q  <= 1'b0;
      xo_q    <= '0;
      yo_q    <= '0;
    end else begin
      frame_q <= bus.iFrame_Cont[0];
      x_q     <= x_d;
      y_q     <= y_d;
      dval_q  <= quad;
      if (bus.iDVAL) begin
        p10_q <= bus.iDATA;
      end
      if (quad) begin
        red_q   <= p01;
        green_q <= green_d;
        blue_q  <= p10_q;
        xo_q    <= x_cur >> 1;
        yo_q    <= y_cur >> 1;
      end
    end
  end

  // Line memory is deliberately unreset: row 0 always overwrites it before row 1 reads it.
  always_ff @(posedge iCLK) begin
    if (bus.iDVAL) begin
      line_mem[addr] <= bus.iDATA;
    end
  end

  assign bus.oRed    = red_q;
  assign bus.oGreen  = green_q;
  assign bus.oBlue   = blue_q;
  assign bus.oDVAL   = dval_q;
  assign bus.oX_Cont = xo_q;
  assign bus.oY_Cont = yo_q;
endmodule
